stepper_phase_decoder: RTL and testbench
========================================

# stepper_phase_decoder

Monitors the four coil-drive lines (in1..in4) produced by the stepper motor controller and reconstructs motion: step events, direction, step size, signed position, step period and fault status. Sits on the receiving end of the coil interface, either in the same FPGA as a closed-loop self-check or on a second board tapping the ULN2003 inputs. Outputs feed the LED/status logic and the system testbench scoreboard.

## Interface
Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before a pattern is accepted (≥1)
- POS_W, 16, width of signed position counter
- PERIOD_W, 24, width of step-period measurement
- TIMEOUT, 2_000_000, cycles without an accepted step before `moving` drops (< 2^PERIOD_W)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous, active-high
- in1, in2, in3, in4  in  1 each  coil lines, asynchronous to clk; pattern = {in1,in2,in3,in4}
- pos_clr  in  1  synchronous clear of `position`
- err_clr  in  1  synchronous clear of sticky `err`
- step_valid  out  1  one-cycle pulse per counted step
- step_dir  out  1  1 = forward, 0 = reverse; valid with step_valid, held after
- step_full  out  1  1 = full step (index delta ±2), 0 = half step
- position  out  POS_W  signed, half-step units
- period  out  PERIOD_W  cycles between last two counted steps; 0 = no reference
- moving  out  1  step counted within last TIMEOUT cycles
- idle  out  1  accepted pattern is 0000 (coils off)
- err  out  1  sticky fault flag

## Operation
- Half-step index table: 1000=0, 1100=1, 0100=2, 0110=3, 0010=4, 0011=5, 0001=6, 1001=7. 0000 = idle. All other patterns invalid.
- Input path: 2-flop synchronizer, then stability filter: candidate register + counter; sample ≠ candidate reloads candidate and clears counter; pattern accepted when it has matched for STABLE_CYCLES cycles and differs from the last accepted pattern.
- On accept of valid index with a valid reference index: delta = (new − ref) mod 8.
  - 1 → step, dir=1, half, position +1; 2 → step, dir=1, full, position +2.
  - 7 → step, dir=0, half, position −1; 6 → step, dir=0, full, position −2.
  - 3, 4, 5 → no step, err set, reference updated to new index, have_prev cleared.
- Valid index without reference (after reset, idle or invalid): becomes reference, no step, no error (resync).
- Accept 0000: idle=1, reference invalidated, moving=0, have_prev cleared, no error.
- Accept invalid pattern: err set, reference invalidated, have_prev cleared.
- Period: since_cnt set to 1 on each counted step, else increments saturating at all-ones. On counted step period <= have_prev ? since_cnt : 0; then have_prev=1.
- moving set on counted step; cleared when since_cnt reaches TIMEOUT or on idle; have_prev also cleared at timeout.
- position wraps modulo 2^POS_W (two's complement).
- Simultaneous events: pos_clr with step → position = step increment (±1/±2); err_clr with new fault → err stays 1.

## Timing
- Reset values: step_valid=0, step_dir=0, step_full=0, position=0, period=0, moving=0, idle=0, err=0; reference invalid, since_cnt=0, have_prev=0, synchronizer and filter cleared.
- Latency: input change stable from before edge 0 → outputs update on edge STABLE_CYCLES+3 (7 at default). Glitches shorter than STABLE_CYCLES cycles after synchronization are discarded.
- step_valid high exactly one cycle per counted step; position/period/step_dir/step_full update on the same edge.
- Two accepts D edges apart → period = D.
- Reset asserted mid-motion: all state cleared immediately; first valid pattern after release is resync only.
- Minimum resolvable step spacing: STABLE_CYCLES+1 cycles.

## Structure
- Shared package stepper_pkg: half-step pattern constants, IDLE_PATTERN, index-lookup function (pattern → {valid, idx[2:0]}); reused by the controller.
- Sub-module phase_glitch_filter: synchronizer + stability filter, outputs accepted pattern and one-cycle accept strobe.
- Top-level decoder: delta classification, position, period/timeout counters, flags.

## Test plan
- Reset, then forward half-step sequence 1000→1100→…→1001→1000, 100 cycles per pattern → 8 step_valid pulses, step_dir=1, step_full=0, position=8, period=100 from 2nd step on.
- Reverse full-step 1100→1001→0011→0110 at 50-cycle spacing after resync → 3 pulses, dir=0, step_full=1, position=−6, period=50.
- 3-cycle glitch 1000→0100→1000 → no accept, no pulse, err=0.
- Jump 1000→0010 (delta 4), then 1111 → err=1, no step; err_clr with no new fault → err=0.
- Stop stepping for TIMEOUT cycles → moving=0; next step gives period=0; drive 0000 → idle=1, next 0100 no step.
- position=32767 plus one forward half step → −32768; pos_clr coincident with +2 step → position=2.

Source files
------------

// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared coil-pattern constants and half-step index lookup
package stepper_pkg;

    localparam logic [3:0] IDLE_PATTERN = 4'b0000;
    localparam logic [3:0] PAT_IDX0 = 4'b1000;
    localparam logic [3:0] PAT_IDX1 = 4'b1100;
    localparam logic [3:0] PAT_IDX2 = 4'b0100;
    localparam logic [3:0] PAT_IDX3 = 4'b0110;
    localparam logic [3:0] PAT_IDX4 = 4'b0010;
    localparam logic [3:0] PAT_IDX5 = 4'b0011;
    localparam logic [3:0] PAT_IDX6 = 4'b0001;
    localparam logic [3:0] PAT_IDX7 = 4'b1001;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } phase_idx_t;

    function automatic phase_idx_t pattern_to_idx(input logic [3:0] pattern);
        phase_idx_t r;
        r = '{valid: 1'b1, idx: 3'd0};
        case (pattern)
            PAT_IDX0: r.idx = 3'd0;
            PAT_IDX1: r.idx = 3'd1;
            PAT_IDX2: r.idx = 3'd2;
            PAT_IDX3: r.idx = 3'd3;
            PAT_IDX4: r.idx = 3'd4;
            PAT_IDX5: r.idx = 3'd5;
            PAT_IDX6: r.idx = 3'd6;
            PAT_IDX7: r.idx = 3'd7;
            default:  r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/phase_glitch_filter.sv
// rtl/phase_glitch_filter.sv - coil-line synchronizer and stability filter
module phase_glitch_filter
    import stepper_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] raw,
    output logic [3:0] pattern,
    output logic       accept
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       cand;
    logic [CNT_W-1:0] cnt;
    logic             have_acc;

    // have_acc lets the very first stable pattern after reset be accepted,
    // even if it equals the reset value of pattern
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            cand     <= '0;
            cnt      <= '0;
            have_acc <= 1'b0;
            pattern  <= IDLE_PATTERN;
            accept   <= 1'b0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            accept <= 1'b0;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end else if (!have_acc || cand != pattern) begin
                pattern  <= cand;
                have_acc <= 1'b1;
                accept   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/stepper_phase_decoder.sv
// rtl/stepper_phase_decoder.sv - reconstructs step events, position and period from coil lines
module stepper_phase_decoder
    import stepper_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int POS_W         = 16,
    parameter int PERIOD_W      = 24,
    parameter int TIMEOUT       = 2_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in1,
    input  logic                    in2,
    input  logic                    in3,
    input  logic                    in4,
    input  logic                    pos_clr,
    input  logic                    err_clr,
    output logic                    step_valid,
    output logic                    step_dir,
    output logic                    step_full,
    output logic signed [POS_W-1:0] position,
    output logic [PERIOD_W-1:0]     period,
    output logic                    moving,
    output logic                    idle,
    output logic                    err
);

    localparam logic [PERIOD_W-1:0] TIMEOUT_CNT = PERIOD_W'(TIMEOUT);

    logic [3:0]              acc_pat;
    logic                    acc;
    phase_idx_t              cur;
    logic                    ref_valid;
    logic [2:0]              ref_idx;
    logic [2:0]              delta;
    logic                    step_ok;
    logic                    is_step;
    logic                    fwd;
    logic                    big;
    logic                    have_prev;
    logic [PERIOD_W-1:0]     since_cnt;
    logic signed [POS_W-1:0] pos_base;
    logic signed [POS_W-1:0] pos_inc;

    phase_glitch_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
        .clk     (clk),
        .rst     (rst),
        .raw     ({in1, in2, in3, in4}),
        .pattern (acc_pat),
        .accept  (acc)
    );

    assign cur   = pattern_to_idx(acc_pat);
    assign delta = cur.idx - ref_idx;

    always_comb begin
        step_ok = 1'b0;
        fwd     = 1'b0;
        big     = 1'b0;
        pos_inc = '0;
        case (delta)
            3'd1: begin step_ok = 1'b1; fwd = 1'b1;             pos_inc = POS_W'(1);  end
            3'd2: begin step_ok = 1'b1; fwd = 1'b1; big = 1'b1; pos_inc = POS_W'(2);  end
            3'd7: begin step_ok = 1'b1;                         pos_inc = POS_W'(-1); end
            3'd6: begin step_ok = 1'b1;             big = 1'b1; pos_inc = POS_W'(-2); end
            default: ;
        endcase
        is_step  = acc && cur.valid && ref_valid && step_ok;
        pos_base = pos_clr ? '0 : position;
    end

    // Later assignments win: a fault on the same edge as err_clr keeps err set,
    // and an idle accept overrides the timeout/step handling of moving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_valid <= 1'b0;
            step_dir   <= 1'b0;
            step_full  <= 1'b0;
            position   <= '0;
            period     <= '0;
            moving     <= 1'b0;
            idle       <= 1'b0;
            err        <= 1'b0;
            ref_valid  <= 1'b0;
            ref_idx    <= '0;
            have_prev  <= 1'b0;
            since_cnt  <= '0;
        end else begin
            step_valid <= 1'b0;
            if (err_clr) err <= 1'b0;
            if (pos_clr) position <= '0;
            if (is_step) begin
                step_valid <= 1'b1;
                step_dir   <= fwd;
                step_full  <= big;
                position   <= pos_base + pos_inc;
                period     <= have_prev ? since_cnt : '0;
                have_prev  <= 1'b1;
                since_cnt  <= PERIOD_W'(1);
                moving     <= 1'b1;
            end else begin
                if (since_cnt != '1) since_cnt <= since_cnt + 1'b1;
                if (since_cnt == TIMEOUT_CNT) begin
                    moving    <= 1'b0;
                    have_prev <= 1'b0;
                end
            end
            if (acc) begin
                if (acc_pat == IDLE_PATTERN) begin
                    idle      <= 1'b1;
                    ref_valid <= 1'b0;
                    moving    <= 1'b0;
                    have_prev <= 1'b0;
                end else if (!cur.valid) begin
                    idle      <= 1'b0;
                    err       <= 1'b1;
                    ref_valid <= 1'b0;
                    have_prev <= 1'b0;
                end else begin
                    idle      <= 1'b0;
                    ref_valid <= 1'b1;
                    ref_idx   <= cur.idx;
                    if (ref_valid && !step_ok) begin
                        err       <= 1'b1;
                        have_prev <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// tb/tb_stepper_phase_decoder.sv - directed self-checking bench for stepper_phase_decoder
module tb_stepper_phase_decoder;

    localparam int STABLE_CYCLES = 4;
    localparam int POS_W         = 10;
    localparam int PERIOD_W      = 24;
    localparam int TIMEOUT       = 1000;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [3:0]              pat_in = 4'b0000;
    logic                    pos_clr = 1'b0;
    logic                    err_clr = 1'b0;
    logic                    step_valid;
    logic                    step_dir;
    logic                    step_full;
    logic signed [POS_W-1:0] position;
    logic [PERIOD_W-1:0]     period;
    logic                    moving;
    logic                    idle;
    logic                    err;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_total = 0;

    logic [3:0] ptab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                             4'b0010, 4'b0011, 4'b0001, 4'b1001};

    typedef struct {
        logic [3:0] pat;
        int         hold;
        bit         pclr;
        bit         eclr;
        int         pulses;
        bit         dir;
        bit         full;
        int         pos;
        int         per;
        bit         mov;
        bit         idl;
        bit         er;
    } vec_t;

    vec_t vecs[$];

    stepper_phase_decoder #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .POS_W         (POS_W),
        .PERIOD_W      (PERIOD_W),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in1        (pat_in[3]),
        .in2        (pat_in[2]),
        .in3        (pat_in[1]),
        .in4        (pat_in[0]),
        .pos_clr    (pos_clr),
        .err_clr    (err_clr),
        .step_valid (step_valid),
        .step_dir   (step_dir),
        .step_full  (step_full),
        .position   (position),
        .period     (period),
        .moving     (moving),
        .idle       (idle),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (step_valid) pulse_total++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] p, input int h, input bit pc, input bit ec,
                       input int pu, input bit d, input bit f, input int ps, input int pe,
                       input bit mv, input bit il, input bit e);
        vec_t v;
        v.pat = p; v.hold = h; v.pclr = pc; v.eclr = ec; v.pulses = pu; v.dir = d;
        v.full = f; v.pos = ps; v.per = pe; v.mov = mv; v.idl = il; v.er = e;
        vecs.push_back(v);
    endtask

    task automatic apply(input logic [3:0] p, input int hold, input bit pc, input bit ec);
        pat_in  = p;
        pos_clr = pc;
        err_clr = ec;
        @(negedge clk);
        pos_clr = 1'b0;
        err_clr = 1'b0;
        repeat (hold - 1) @(negedge clk);
    endtask

    // Raises pos_clr/err_clr for exactly the edge at which the new pattern's step lands
    task automatic apply_timed(input logic [3:0] p, input bit pc, input bit ec);
        pat_in = p;
        repeat (STABLE_CYCLES + 3) @(negedge clk);
        pos_clr = pc;
        err_clr = ec;
        @(negedge clk);
        pos_clr = 1'b0;
        err_clr = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int start;
        int idx;

        //   pat      hold  pc ec  pul dir full  pos  per  mov idl err
        add(4'b0000,   20, 0, 0,   0, 0, 0,    0,   0,  0, 1, 0);
        add(4'b1000,  100, 0, 0,   0, 0, 0,    0,   0,  0, 0, 0);
        add(4'b1100,  100, 0, 0,   1, 1, 0,    1,   0,  1, 0, 0);
        add(4'b0100,  100, 0, 0,   1, 1, 0,    2, 100,  1, 0, 0);
        add(4'b0110,  100, 0, 0,   1, 1, 0,    3, 100,  1, 0, 0);
        add(4'b0010,  100, 0, 0,   1, 1, 0,    4, 100,  1, 0, 0);
        add(4'b0011,  100, 0, 0,   1, 1, 0,    5, 100,  1, 0, 0);
        add(4'b0001,  100, 0, 0,   1, 1, 0,    6, 100,  1, 0, 0);
        add(4'b1001,  100, 0, 0,   1, 1, 0,    7, 100,  1, 0, 0);
        add(4'b1000,  100, 0, 0,   1, 1, 0,    8, 100,  1, 0, 0);
        add(4'b0000,   50, 1, 0,   0, 1, 0,    0, 100,  0, 1, 0);
        add(4'b1100,   50, 0, 0,   0, 1, 0,    0, 100,  0, 0, 0);
        add(4'b1001,   50, 0, 0,   1, 0, 1,   -2,   0,  1, 0, 0);
        add(4'b0011,   50, 0, 0,   1, 0, 1,   -4,  50,  1, 0, 0);
        add(4'b0110,   50, 0, 0,   1, 0, 1,   -6,  50,  1, 0, 0);
        add(4'b0000,   30, 0, 0,   0, 0, 1,   -6,  50,  0, 1, 0);
        add(4'b1000,   30, 0, 0,   0, 0, 1,   -6,  50,  0, 0, 0);
        add(4'b0100,    3, 0, 0,   0, 0, 1,   -6,  50,  0, 0, 0);
        add(4'b1000,   30, 0, 0,   0, 0, 1,   -6,  50,  0, 0, 0);
        add(4'b0010,   30, 0, 0,   0, 0, 1,   -6,  50,  0, 0, 1);
        add(4'b1111,   30, 0, 0,   0, 0, 1,   -6,  50,  0, 0, 1);
        add(4'b1111,   10, 0, 1,   0, 0, 1,   -6,  50,  0, 0, 0);
        add(4'b1000,   20, 0, 0,   0, 0, 1,   -6,  50,  0, 0, 0);
        add(4'b1100,   20, 0, 0,   1, 1, 0,   -5,   0,  1, 0, 0);
        add(4'b0100, 1000, 0, 0,   1, 1, 0,   -4,  20,  1, 0, 0);
        add(4'b0100,  100, 0, 0,   0, 1, 0,   -4,  20,  0, 0, 0);
        add(4'b0110,   20, 0, 0,   1, 1, 0,   -3,   0,  1, 0, 0);
        add(4'b0000,   20, 0, 0,   0, 1, 0,   -3,   0,  0, 1, 0);
        add(4'b0100,   20, 0, 0,   0, 1, 0,   -3,   0,  0, 0, 0);

        repeat (2) @(negedge clk);
        chk("reset step_valid", step_valid, 0);
        chk("reset step_dir",   step_dir,   0);
        chk("reset step_full",  step_full,  0);
        chk("reset position",   int'(position), 0);
        chk("reset period",     int'(period), 0);
        chk("reset moving",     moving, 0);
        chk("reset idle",       idle,   0);
        chk("reset err",        err,    0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            start = pulse_total;
            apply(vecs[i].pat, vecs[i].hold, vecs[i].pclr, vecs[i].eclr);
            chk($sformatf("v%0d pulses", i),    pulse_total - start, vecs[i].pulses);
            chk($sformatf("v%0d step_dir", i),  step_dir,  vecs[i].dir);
            chk($sformatf("v%0d step_full", i), step_full, vecs[i].full);
            chk($sformatf("v%0d position", i),  int'(position), vecs[i].pos);
            chk($sformatf("v%0d period", i),    int'(period), vecs[i].per);
            chk($sformatf("v%0d moving", i),    moving, vecs[i].mov);
            chk($sformatf("v%0d idle", i),      idle,   vecs[i].idl);
            chk($sformatf("v%0d err", i),       err,    vecs[i].er);
        end

        // Wrap: clear, 255 full steps to 510, then +1 to 511 and +1 to -512
        apply(4'b0100, 6, 1, 0);
        chk("wrap clear", int'(position), 0);
        idx = 2;
        start = pulse_total;
        for (int k = 0; k < 255; k++) begin
            idx = (idx + 2) % 8;
            apply(ptab[idx], STABLE_CYCLES + 2, 0, 0);
        end
        repeat (10) @(negedge clk);
        chk("fast pulses", pulse_total - start, 255);
        chk("fast position", int'(position), 510);
        chk("fast period", int'(period), STABLE_CYCLES + 2);
        idx = (idx + 1) % 8;
        apply(ptab[idx], 20, 0, 0);
        chk("pos max", int'(position), 511);
        idx = (idx + 1) % 8;
        apply(ptab[idx], 20, 0, 0);
        chk("pos wrap", int'(position), -512);
        chk("pos wrap dir", step_dir, 1);

        start = pulse_total;
        idx = (idx + 2) % 8;
        apply_timed(ptab[idx], 1, 0);
        chk("clr+step position", int'(position), 2);
        chk("clr+step pulses", pulse_total - start, 1);
        chk("clr+step full", step_full, 1);

        apply_timed(4'b1111, 0, 1);
        chk("errclr+fault err", err, 1);

        // Reset in mid-motion, then resync-only on release
        apply(4'b1000, 20, 0, 0);
        apply(4'b1100, 20, 0, 0);
        chk("pre-reset moving", moving, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst position", int'(position), 0);
        chk("midrst moving", moving, 0);
        chk("midrst err", err, 0);
        chk("midrst dir", step_dir, 0);
        rst = 1'b0;
        start = pulse_total;
        repeat (30) @(negedge clk);
        chk("post-rst pulses", pulse_total - start, 0);
        chk("post-rst position", int'(position), 0);
        chk("post-rst idle", idle, 0);
        apply(4'b0100, 30, 0, 0);
        chk("post-rst step pos", int'(position), 1);
        chk("post-rst step period", int'(period), 0);
        chk("post-rst moving", moving, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
